// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// LED pattern generator for board bring-up and status display. After reset
// release a startup counter runs for START_DELAY cycles; the "waiting" LED is
// lit until it expires. Once ready, a divider produces one pattern step every
// STEP_DIV cycles, and the pattern advances through one of four modes:
// ROTATE, BOUNCE, WIPE or COUNT.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = divider and pattern advance, 0 = both frozen
//   mode        in   0 ROTATE, 1 BOUNCE, 2 WIPE, 3 COUNT
//   leds        out  N_LEDS pattern drive (active high by default)
//   wait_led    out  high while the startup delay is running
//   step_pulse  out  one-cycle strobe coincident with each pattern update
//
// Build option:
//   LED_ACTIVE_LOW_EN  when defined, leds and wait_led are inverted at the
//                      ports for sink-driven LEDs; step_pulse is unaffected.
// ---------------------------------------------------------------------------
module led_sequencer #(
    parameter int N_LEDS      = 4,
    parameter int STEP_DIV    = 1200000,
    parameter int START_DELAY = 12000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              wait_led,
    output logic              step_pulse
);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_WIPE   = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int START_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int DIV_W   = (STEP_DIV > 1)    ? $clog2(STEP_DIV)    : 1;

    localparam logic [START_W-1:0] START_LAST = START_W'(START_DELAY - 1);
    localparam logic [START_W-1:0] START_ONE  = START_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [N_LEDS-1:0]  PAT_ONE    = N_LEDS'(1);

    logic [START_W-1:0] startCnt_q, startCnt_d;
    logic               ready_q,    ready_d;
    logic [DIV_W-1:0]   divCnt_q,   divCnt_d;
    logic [N_LEDS-1:0]  pattern_q,  pattern_d;
    dir_e               dir_q,      dir_d;
    mode_e              modeLat_q,  modeLat_d;
    logic               stepPulse_q, stepPulse_d;

    logic               stepTake;
    mode_e              modeIn;
    logic [N_LEDS-1:0]  ledsActive;

    assign modeIn = mode_e'(mode);

    // Startup delay: count up while not ready, then set ready and hold the
    // counter at its terminal value so it can never wrap.
    always_comb begin
        startCnt_d = startCnt_q;
        ready_d    = ready_q;
        if (!ready_q) begin
            if (startCnt_q == START_LAST) begin
                ready_d = 1'b1;
            end else begin
                startCnt_d = startCnt_q + START_ONE;
            end
        end
    end

    // Step divider: runs only when ready and enabled. Disabling clears it
    // rather than pausing it, so re-enable always gives a full interval.
    always_comb begin
        divCnt_d = '0;
        stepTake = 1'b0;
        if (ready_q && enable) begin
            if (divCnt_q == DIV_LAST) begin
                stepTake = 1'b1;
            end else begin
                divCnt_d = divCnt_q + DIV_ONE;
            end
        end
    end

    // Pattern update on each step. A new mode seen at a step only loads that
    // mode's initial value; advancing starts from the following step.
    always_comb begin
        pattern_d   = pattern_q;
        dir_d       = dir_q;
        modeLat_d   = modeLat_q;
        stepPulse_d = stepTake;
        if (stepTake) begin
            if (modeIn != modeLat_q) begin
                modeLat_d = modeIn;
                dir_d     = DIR_UP;
                pattern_d = (modeIn == MODE_COUNT) ? '0 : PAT_ONE;
            end else begin
                unique case (modeLat_q)
                    MODE_ROTATE: begin
                        if (pattern_q == '0) begin
                            pattern_d = PAT_ONE;
                        end else begin
                            pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
                        end
                    end
                    MODE_BOUNCE: begin
                        // The end bit reverses direction and moves away from
                        // the edge on the same step, so ends are shown once.
                        if (pattern_q == '0) begin
                            pattern_d = PAT_ONE;
                            dir_d     = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            if (pattern_q[N_LEDS-1]) begin
                                dir_d     = DIR_DOWN;
                                pattern_d = pattern_q >> 1;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                dir_d     = DIR_UP;
                                pattern_d = pattern_q << 1;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    MODE_WIPE: begin
                        // Two-wide window: feed a 1 in from bit 0 for two
                        // steps, then let it shift off the top (period N+2).
                        pattern_d = (pattern_q << 1) |
                                    (((pattern_q == '0) || (pattern_q == PAT_ONE)) ? PAT_ONE : '0);
                    end
                    MODE_COUNT: begin
                        pattern_d = pattern_q + PAT_ONE;
                    end
                    default: begin
                        pattern_d = pattern_q;
                    end
                endcase
            end
        end
    end

    // State registers, all cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startCnt_q  <= '0;
            ready_q     <= 1'b0;
            divCnt_q    <= '0;
            pattern_q   <= '0;
            dir_q       <= DIR_UP;
            modeLat_q   <= MODE_ROTATE;
            stepPulse_q <= 1'b0;
        end else begin
            startCnt_q  <= startCnt_d;
            ready_q     <= ready_d;
            divCnt_q    <= divCnt_d;
            pattern_q   <= pattern_d;
            dir_q       <= dir_d;
            modeLat_q   <= modeLat_d;
            stepPulse_q <= stepPulse_d;
        end
    end

    // LEDs stay dark until ready, regardless of the internal pattern.
    assign ledsActive = ready_q ? pattern_q : '0;
    assign step_pulse = stepPulse_q;

`ifdef LED_ACTIVE_LOW_EN
    assign leds     = ~ledsActive;
    assign wait_led = ready_q;
`else
    assign leds     = ledsActive;
    assign wait_led = ~ready_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed bench for led_sequencer with N_LEDS=4, STEP_DIV=4, START_DELAY=10.
// Each scenario drives enable/mode, waits for step strobes and compares the
// LED pattern and strobe spacing against hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int N_LEDS      = 4;
    localparam int STEP_DIV    = 4;
    localparam int START_DELAY = 10;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [1:0]        mode;
    logic [N_LEDS-1:0] leds;
    logic              wait_led;
    logic              step_pulse;

    int testsRun    = 0;
    int testsFailed = 0;

    led_sequencer #(
        .N_LEDS      (N_LEDS),
        .STEP_DIV    (STEP_DIV),
        .START_DELAY (START_DELAY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .leds       (leds),
        .wait_led   (wait_led),
        .step_pulse (step_pulse)
    );

    // Free-running clock, rising edges at 5, 15, 25 ... so negedges are a
    // safe place to sample registered outputs and change inputs.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the functional inputs.
    task automatic applyStimulus(input logic en, input logic [1:0] md);
        enable = en;
        mode   = md;
    endtask

    // Assert reset for two cycles and release it on a negedge; the next
    // rising edge is edge 1 of the startup delay.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Verify the full startup delay: waiting through edge 9, ready at edge 10.
    task automatic checkStartup(input string tag);
        repeat (START_DELAY - 1) @(negedge clk);
        checkOutput({tag, "_wait9"}, {31'd0, wait_led}, 32'd1);
        checkOutput({tag, "_leds9"}, {28'd0, leds}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_wait10"}, {31'd0, wait_led}, 32'd0);
        checkOutput({tag, "_leds10"}, {28'd0, leds}, 32'd0);
    endtask

    // Wait (bounded) for the next step strobe; returns cycles waited.
    task automatic waitStep(output int cycles);
        logic got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (step_pulse) got = 1'b1;
        end
        if (!got) checkOutput("stepTimeout", 32'd0, 32'd1);
    endtask

    // Wait for one step and compare both the LEDs and the strobe spacing.
    task automatic stepCheck(input string tag, input logic [3:0] expLeds,
                             input int expGap);
        int gap;
        waitStep(gap);
        checkOutput({tag, "_gap"}, gap, expGap);
        checkOutput(tag, {28'd0, leds}, {28'd0, expLeds});
    endtask

    // Directed scenarios, run in sequence.
    initial begin
        int               gap;
        logic             sawPulse;
        logic             ledsMoved;
        logic [3:0]       rotSeq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0]       bncSeq  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [3:0]       wipSeq  [7] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100,
                                          4'b1000, 4'b0000, 4'b0001};

        rst_n = 1'b0;
        applyStimulus(1'b1, 2'd0);

        // Reset state while rst_n is held low.
        @(negedge clk);
        checkOutput("rst_leds", {28'd0, leds}, 32'd0);
        checkOutput("rst_wait", {31'd0, wait_led}, 32'd1);
        checkOutput("rst_pulse", {31'd0, step_pulse}, 32'd0);

        // Startup then ROTATE for five steps.
        $display("[TB] startup and ROTATE");
        doReset();
        checkStartup("start");
        for (int i = 0; i < 5; i++) stepCheck($sformatf("rot%0d", i), rotSeq[i], STEP_DIV);
        @(negedge clk);
        checkOutput("rot_pulse_one_cycle", {31'd0, step_pulse}, 32'd0);

        // COUNT from reset: first step loads 0, then counts and wraps.
        $display("[TB] COUNT");
        applyStimulus(1'b1, 2'd3);
        doReset();
        checkStartup("cntStart");
        stepCheck("cnt_load", 4'b0000, STEP_DIV);
        for (int i = 1; i <= 16; i++) stepCheck($sformatf("cnt%0d", i), 4'(i), STEP_DIV);

        // BOUNCE from reset.
        $display("[TB] BOUNCE");
        applyStimulus(1'b1, 2'd1);
        doReset();
        checkStartup("bncStart");
        for (int i = 0; i < 8; i++) stepCheck($sformatf("bnc%0d", i), bncSeq[i], STEP_DIV);

        // WIPE from reset.
        $display("[TB] WIPE");
        applyStimulus(1'b1, 2'd2);
        doReset();
        checkStartup("wipStart");
        for (int i = 0; i < 7; i++) stepCheck($sformatf("wip%0d", i), wipSeq[i], STEP_DIV);

        // Mode switch mid-interval: ROTATE at 0100, then BOUNCE.
        $display("[TB] mode switch");
        applyStimulus(1'b1, 2'd0);
        doReset();
        checkStartup("swStart");
        for (int i = 0; i < 3; i++) stepCheck($sformatf("sw_rot%0d", i), rotSeq[i], STEP_DIV);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 2'd1);
        stepCheck("sw_load", 4'b0001, STEP_DIV - 2);
        stepCheck("sw_up", 4'b0010, STEP_DIV);

        // Enable gating: drop enable two cycles into an interval.
        $display("[TB] enable gating");
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 2'd1);
        sawPulse  = 1'b0;
        ledsMoved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_pulse) sawPulse = 1'b1;
            if (leds !== 4'b0010) ledsMoved = 1'b1;
        end
        checkOutput("gate_no_pulse", {31'd0, sawPulse}, 32'd0);
        checkOutput("gate_frozen", {31'd0, ledsMoved}, 32'd0);
        applyStimulus(1'b1, 2'd1);
        stepCheck("gate_resume", 4'b0100, STEP_DIV);

        // Asynchronous reset mid-run at 1000, then full startup again.
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 2'd0);
        doReset();
        checkStartup("mrStart");
        for (int i = 0; i < 4; i++) stepCheck($sformatf("mr_rot%0d", i), rotSeq[i], STEP_DIV);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_leds_async", {28'd0, leds}, 32'd0);
        checkOutput("mr_wait_async", {31'd0, wait_led}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        checkStartup("mrRestart");
        stepCheck("mr_first", 4'b0001, STEP_DIV);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
